// File: rtl/rv32_alu.sv
// RV32I register-register ALU for the execute stage.
// Computes one of the ten R-type operations and registers the result one clock later.
module rv32_alu (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  funct7,
  input  logic [2:0]  funct3,
  input  logic [31:0] source1,
  input  logic [31:0] source2,
  output logic [31:0] result
);

  localparam int unsigned W   = 32;
  localparam int unsigned SHW = 5;

  logic           alt_c;
  logic [SHW-1:0] shamt_c;
  logic [W-1:0]   result_d;
  logic [W-1:0]   result_q;
  logic           unused_c;

  assign alt_c   = funct7[5];
  assign shamt_c = source2[SHW-1:0];

  // Only funct7[5] and the low five bits of source2 in shifts are meaningful.
  assign unused_c = ^{funct7[6], funct7[4:0], source2[W-1:SHW]};

  // Operation select from funct3, with funct7[5] picking SUB and SRA.
  always_comb begin
    result_d = '0;
    case (funct3)
      3'b000: result_d = alt_c ? (source1 - source2) : (source1 + source2);
      3'b001: result_d = source1 << shamt_c;
      3'b010: result_d = W'($signed(source1) < $signed(source2));
      3'b011: result_d = W'(source1 < source2);
      3'b100: result_d = source1 ^ source2;
      3'b101: result_d = alt_c ? W'($signed(source1) >>> shamt_c) : (source1 >> shamt_c);
      3'b110: result_d = source1 | source2;
      3'b111: result_d = source1 & source2;
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_rv32_alu.sv
// Self-checking bench for rv32_alu: directed cases plus randomized traffic
// compared against an arithmetic reference model.
module tb_rv32_alu;

  logic        clock;
  logic        reset;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] source1;
  logic [31:0] source2;
  logic [31:0] result;

  int vectors;
  int miscompares;

  rv32_alu dut (
    .clock   (clock),
    .reset   (reset),
    .funct7  (funct7),
    .funct3  (funct3),
    .source1 (source1),
    .source2 (source2),
    .result  (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: the RV32I operation written as plain arithmetic.
  function automatic logic [31:0] ref_alu(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    logic [31:0] fill;
    logic [31:0] r;
    sh = int'(b % 32);
    r  = 32'h0;
    case (f3)
      3'd0: r = f7[5] ? a - b : a + b;
      3'd1: r = a << sh;
      3'd2: begin
        if (a[31] != b[31]) r = a[31] ? 32'd1 : 32'd0;
        else r = (a < b) ? 32'd1 : 32'd0;
      end
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: begin
        fill = (f7[5] && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
        r = (a >> sh) | fill;
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  task automatic drive(input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b);
    funct7  = f7;
    funct3  = f3;
    source1 = a;
    source2 = b;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(7'h00, 3'b000, 32'd5, 32'd7);
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (result !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_hold[%0d] got %h want %h", i, result, 32'h0);
      end
    end
    reset = 1'b0;
    step();
    vectors++;
    if (result !== 32'd12) begin
      miscompares++;
      $display("FAIL reset_release got %h want %h", result, 32'd12);
    end
  endtask

  task automatic test_add_sub();
    logic [6:0]  f7[4]  = '{7'h00, 7'h20, 7'h20, 7'h00};
    logic [31:0] a[4]   = '{32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] b[4]   = '{32'd1, 32'd1, 32'd1, 32'd1};
    logic [31:0] exp[4] = '{32'd3, 32'd1, 32'hFFFF_FFFF, 32'h0};
    for (int i = 0; i < 4; i++) begin
      drive(f7[i], 3'b000, a[i], b[i]);
      step();
      vectors++;
      if (result !== exp[i]) begin
        miscompares++;
        $display("FAIL add_sub[%0d] got %h want %h", i, result, exp[i]);
      end
    end
  endtask

  task automatic test_shifts();
    logic [6:0]  f7[9]  = '{7'h00, 7'h00, 7'h20, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00, 7'h20};
    logic [2:0]  f3[9]  = '{3'b001, 3'b101, 3'b101, 3'b001, 3'b101, 3'b101, 3'b001, 3'b101, 3'b101};
    logic [31:0] b[9]   = '{32'd4, 32'd4, 32'd4, 32'h24, 32'h24, 32'h24, 32'd0, 32'd0, 32'h20};
    logic [31:0] exp[9] = '{32'h0, 32'h0800_0000, 32'hF800_0000,
                            32'h0, 32'h0800_0000, 32'hF800_0000,
                            32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    for (int i = 0; i < 9; i++) begin
      drive(f7[i], f3[i], 32'h8000_0000, b[i]);
      step();
      vectors++;
      if (result !== exp[i]) begin
        miscompares++;
        $display("FAIL shift[%0d] got %h want %h", i, result, exp[i]);
      end
    end
  endtask

  task automatic test_compares();
    logic [2:0]  f3[4]  = '{3'b010, 3'b011, 3'b010, 3'b011};
    logic [31:0] a[4]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678};
    logic [31:0] b[4]   = '{32'd1, 32'd1, 32'h1234_5678, 32'h1234_5678};
    logic [31:0] exp[4] = '{32'd1, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 4; i++) begin
      drive(7'h00, f3[i], a[i], b[i]);
      step();
      vectors++;
      if (result !== exp[i]) begin
        miscompares++;
        $display("FAIL compare[%0d] got %h want %h", i, result, exp[i]);
      end
    end
  endtask

  task automatic test_logic();
    logic [6:0]  f7[4]  = '{7'h00, 7'h00, 7'h00, 7'h20};
    logic [2:0]  f3[4]  = '{3'b100, 3'b110, 3'b111, 3'b111};
    logic [31:0] exp[4] = '{32'h0FF0_0FF0, 32'hFFF0_FFF0, 32'hF000_F000, 32'hF000_F000};
    for (int i = 0; i < 4; i++) begin
      drive(f7[i], f3[i], 32'hF0F0_F0F0, 32'hFF00_FF00);
      step();
      vectors++;
      if (result !== exp[i]) begin
        miscompares++;
        $display("FAIL logic[%0d] got %h want %h", i, result, exp[i]);
      end
    end
  endtask

  // Cycles through all ten operations, with a reset pulse mid-stream.
  task automatic test_back_to_back();
    logic [6:0]  ops_f7[10] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
    logic [2:0]  ops_f3[10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    logic [31:0] a, b, exp;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      drive(ops_f7[i % 10], ops_f3[i % 10], a, b);
      reset = (i == 17);
      exp = reset ? 32'h0 : ref_alu(ops_f7[i % 10], ops_f3[i % 10], a, b);
      step();
      // Disturb inputs between edges; the registered result must not move.
      drive(7'($urandom), 3'($urandom), $urandom, $urandom);
      #2;
      vectors++;
      if (result !== exp) begin
        miscompares++;
        $display("FAIL back_to_back[%0d] got %h want %h", i, result, exp);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a, b, exp;
    for (int i = 0; i < 300; i++) begin
      f7 = 7'($urandom);
      f3 = 3'($urandom);
      a  = (i % 8 == 0) ? 32'h8000_0000 : $urandom;
      b  = (i % 5 == 0) ? a : $urandom;
      drive(f7, f3, a, b);
      exp = ref_alu(f7, f3, a, b);
      step();
      vectors++;
      if (result !== exp) begin
        miscompares++;
        $display("FAIL random[%0d] f7=%h f3=%0d a=%h b=%h got %h want %h",
                 i, f7, f3, a, b, result, exp);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    drive(7'h00, 3'b000, 32'd0, 32'd0);
    test_reset();
    test_add_sub();
    test_shifts();
    test_compares();
    test_logic();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
